// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single byte-wide RAM port between instruction fetch
// and the MEM stage. Each access is split into byte transfers, and read bytes
// are reassembled into a little-endian word.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  state_t            state_reg, state_next;
  logic [1:0]        cnt_reg, cnt_next;      // index of the byte now on the RAM port
  logic [1:0]        last_reg, last_next;    // index of the final byte (N-1)
  logic [ADDR_W-1:0] ram_a_reg, ram_a_next;
  logic              ram_wr_reg, ram_wr_next;
  logic [7:0]        ram_dout_reg, ram_dout_next;
  logic              if_done_reg, if_done_next;
  logic [31:0]       if_data_reg, if_data_next;
  logic              mem_done_reg, mem_done_next;
  logic [31:0]       mem_rdata_reg, mem_rdata_next;
  logic [31:0]       cap_reg, cap_next;      // partially assembled read word

  logic [31:0]       cap_merged;
  logic [7:0]        wdata_b [4];
  logic [1:0]        mem_last;

  // Lengths 2 and 3 both select a full 4-byte word.
  assign mem_last = (mem_len == 2'd0) ? 2'd0 :
                    (mem_len == 2'd1) ? 2'd1 : 2'd3;

  // Byte lanes: drop the incoming RAM byte into the lane selected by the
  // counter, and split the store data into addressable bytes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign cap_merged[8*gi +: 8] = (cnt_reg == 2'(gi)) ? ram_din : cap_reg[8*gi +: 8];
      assign wdata_b[gi]           = mem_wdata[8*gi +: 8];
    end
  endgenerate

  // Next-state and next-output logic for the arbitration/transfer FSM.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    last_next      = last_reg;
    ram_a_next     = ram_a_reg;
    ram_wr_next    = ram_wr_reg;
    ram_dout_next  = ram_dout_reg;
    if_done_next   = 1'b0;
    if_data_next   = if_data_reg;
    mem_done_next  = 1'b0;
    mem_rdata_next = mem_rdata_reg;
    cap_next       = cap_reg;
    case (state_reg)
      IDLE: begin
        ram_wr_next = 1'b0;
        // A requester still showing done holds a stale request; skip it.
        if (mem_req && !mem_done_reg) begin
          cnt_next      = 2'd0;
          last_next     = mem_last;
          ram_a_next    = mem_addr;
          ram_wr_next   = mem_we;
          ram_dout_next = wdata_b[0];
          cap_next      = 32'd0;
          state_next    = mem_we ? MEM_WR : MEM_RD;
        end else if (if_req && !if_done_reg) begin
          cnt_next   = 2'd0;
          last_next  = 2'd3;
          ram_a_next = if_addr;
          cap_next   = 32'd0;
          state_next = IF_RD;
        end
      end
      IF_RD: begin
        if (!if_req) begin
          // Fetch abandoned (e.g. redirect): drop it without a done pulse.
          ram_wr_next = 1'b0;
          state_next  = IDLE;
        end else begin
          cap_next = cap_merged;
          if (cnt_reg == last_reg) begin
            if_done_next = 1'b1;
            if_data_next = cap_merged;
            state_next   = IDLE;
          end else begin
            cnt_next   = cnt_reg + 2'd1;
            ram_a_next = ram_a_reg + A_ONE;
          end
        end
      end
      MEM_RD: begin
        cap_next = cap_merged;
        if (cnt_reg == last_reg) begin
          mem_done_next  = 1'b1;
          mem_rdata_next = cap_merged;
          state_next     = IDLE;
        end else begin
          cnt_next   = cnt_reg + 2'd1;
          ram_a_next = ram_a_reg + A_ONE;
        end
      end
      MEM_WR: begin
        if (cnt_reg == last_reg) begin
          ram_wr_next   = 1'b0;
          mem_done_next = 1'b1;
          state_next    = IDLE;
        end else begin
          cnt_next      = cnt_reg + 2'd1;
          ram_a_next    = ram_a_reg + A_ONE;
          ram_dout_next = wdata_b[cnt_reg + 2'd1];
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 2'd0;
      last_reg      <= 2'd0;
      ram_a_reg     <= '0;
      ram_wr_reg    <= 1'b0;
      ram_dout_reg  <= 8'd0;
      if_done_reg   <= 1'b0;
      if_data_reg   <= 32'd0;
      mem_done_reg  <= 1'b0;
      mem_rdata_reg <= 32'd0;
      cap_reg       <= 32'd0;
    end else if (rdy) begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      last_reg      <= last_next;
      ram_a_reg     <= ram_a_next;
      ram_wr_reg    <= ram_wr_next;
      ram_dout_reg  <= ram_dout_next;
      if_done_reg   <= if_done_next;
      if_data_reg   <= if_data_next;
      mem_done_reg  <= mem_done_next;
      mem_rdata_reg <= mem_rdata_next;
      cap_reg       <= cap_next;
    end
  end

  assign ram_a     = ram_a_reg;
  assign ram_wr    = ram_wr_reg;
  assign ram_dout  = ram_dout_reg;
  assign if_done   = if_done_reg;
  assign if_data   = if_data_reg;
  assign mem_done  = mem_done_reg;
  assign mem_rdata = mem_rdata_reg;
  assign mem_stall = mem_req & ~mem_done_reg;

endmodule
